// File: rtl/extmem_pkg.sv
// Shared types and constants for the extended-memory arbiter.
package extmem_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 12;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_ARM = 1'b1;

endpackage

// File: rtl/extmem_arbiter_if.sv
// Requester ports (cpu, arm) and the single BRAM port seen by the arbiter.
interface extmem_arbiter_if;
  import extmem_pkg::*;

  logic  cpustrobe;
  addr_t cpuaddr;
  logic  cpuwrite;
  data_t cpuwdat;
  data_t cpurdat;
  logic  cpudone;

  logic  armstrobe;
  addr_t armaddr;
  logic  armwrite;
  data_t armwdat;
  data_t armrdat;
  logic  armdone;

  addr_t bramaddr;
  data_t bramwdat;
  data_t bramrdat;
  logic  bramenab;
  logic  bramwena;
  logic  errflag;

  modport slave (
    input  cpustrobe, cpuaddr, cpuwrite, cpuwdat,
    output cpurdat, cpudone,
    input  armstrobe, armaddr, armwrite, armwdat,
    output armrdat, armdone,
    output bramaddr, bramwdat, bramenab, bramwena,
    input  bramrdat,
    output errflag
  );

  modport master (
    output cpustrobe, cpuaddr, cpuwrite, cpuwdat,
    input  cpurdat, cpudone,
    output armstrobe, armaddr, armwrite, armwdat,
    input  armrdat, armdone,
    input  bramaddr, bramwdat, bramenab, bramwena,
    output bramrdat,
    input  errflag
  );

endinterface

// File: rtl/extmem_reqlatch.sv
// Per-requester capture: pending flag, latched request, read-data register,
// completion pulse and sticky overrun error.
module extmem_reqlatch
  import extmem_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  accept_i,
  input  logic  strobe_i,
  input  addr_t addr_i,
  input  logic  write_i,
  input  data_t wdat_i,
  input  logic  complete_i,
  input  data_t bramrdat_i,
  output logic  pend_o,
  output addr_t addr_o,
  output logic  write_o,
  output data_t wdat_o,
  output data_t rdat_o,
  output logic  done_o,
  output logic  err_o
);

  logic  pend_q, pend_d;
  addr_t addr_q, addr_d;
  logic  write_q, write_d;
  data_t wdat_q, wdat_d;
  data_t rdat_q, rdat_d;
  logic  done_q, done_d;
  logic  err_q, err_d;

  // pend clears on the edge that raises done, so a strobe in the done cycle is accepted
  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (complete_i) begin
      pend_d = 1'b0;
      done_d = 1'b1;
      if (!write_q) rdat_d = bramrdat_i;
    end
    if (accept_i && strobe_i) begin
      if (pend_q) begin
        err_d = 1'b1;
      end else begin
        pend_d  = 1'b1;
        addr_d  = addr_i;
        write_d = write_i;
        wdat_d  = wdat_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pend_o  = pend_q;
  assign addr_o  = addr_q;
  assign write_o = write_q;
  assign wdat_o  = wdat_q;
  assign rdat_o  = rdat_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: rtl/extmem_arbiter.sv
// Two-port (cpu/arm) arbiter onto one BRAM port: cpu priority with a
// starvation limit that forces the arm port through.
module extmem_arbiter
  import extmem_pkg::*;
#(
  parameter int unsigned RDLAT  = 2,
  parameter int unsigned STARVE = 4
) (
  input logic              CLOCK,
  input logic              RESET_N,
  extmem_arbiter_if.slave  bus
);

  localparam logic [2:0] RDLAT_C  = RDLAT[2:0];
  localparam logic [3:0] STARVE_C = STARVE[3:0];

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [3:0] starve_q, starve_d;
  logic       win_q, win_d;
  logic       ready_q;

  logic  sel, enab, finish;
  logic  cpu_pend, arm_pend;
  addr_t cpu_addr, arm_addr;
  logic  cpu_write, arm_write;
  data_t cpu_wdat, arm_wdat;
  logic  cpu_err, arm_err;

  // Strobes are ignored on the first edge after reset release
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) ready_q <= 1'b0;
    else          ready_q <= 1'b1;
  end

  assign finish = (state_q == ACCESS) && (count_q == 3'd1);

  extmem_reqlatch u_cpu (
    .clk_i      (CLOCK),
    .rst_ni     (RESET_N),
    .accept_i   (ready_q),
    .strobe_i   (bus.cpustrobe),
    .addr_i     (bus.cpuaddr),
    .write_i    (bus.cpuwrite),
    .wdat_i     (bus.cpuwdat),
    .complete_i (finish && (win_q == PORT_CPU)),
    .bramrdat_i (bus.bramrdat),
    .pend_o     (cpu_pend),
    .addr_o     (cpu_addr),
    .write_o    (cpu_write),
    .wdat_o     (cpu_wdat),
    .rdat_o     (bus.cpurdat),
    .done_o     (bus.cpudone),
    .err_o      (cpu_err)
  );

  extmem_reqlatch u_arm (
    .clk_i      (CLOCK),
    .rst_ni     (RESET_N),
    .accept_i   (ready_q),
    .strobe_i   (bus.armstrobe),
    .addr_i     (bus.armaddr),
    .write_i    (bus.armwrite),
    .wdat_i     (bus.armwdat),
    .complete_i (finish && (win_q == PORT_ARM)),
    .bramrdat_i (bus.bramrdat),
    .pend_o     (arm_pend),
    .addr_o     (arm_addr),
    .write_o    (arm_write),
    .wdat_o     (arm_wdat),
    .rdat_o     (bus.armrdat),
    .done_o     (bus.armdone),
    .err_o      (arm_err)
  );

  assign bus.errflag = cpu_err | arm_err;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    win_d    = win_q;
    starve_d = starve_q;
    sel      = win_q;
    enab     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_pend || arm_pend) begin
          win_d = (arm_pend && (!cpu_pend || starve_q == STARVE_C)) ? PORT_ARM : PORT_CPU;
          if (win_d == PORT_CPU && arm_pend)
            starve_d = (starve_q == STARVE_C) ? starve_q : starve_q + 4'd1;
          else
            starve_d = '0;
          sel     = win_d;
          enab    = 1'b1;
          count_d = RDLAT_C;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        enab = 1'b1;
        if (count_q == 3'd1) state_d = DONE;
        else                 count_d = count_q - 3'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      count_q  <= '0;
      starve_q <= '0;
      win_q    <= PORT_CPU;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      win_q    <= win_d;
    end
  end

  always_comb begin
    bus.bramenab = enab;
    bus.bramaddr = '0;
    bus.bramwdat = '0;
    bus.bramwena = 1'b0;
    if (enab) begin
      if (sel == PORT_ARM) begin
        bus.bramaddr = arm_addr;
        bus.bramwdat = arm_wdat;
        bus.bramwena = arm_write;
      end else begin
        bus.bramaddr = cpu_addr;
        bus.bramwdat = cpu_wdat;
        bus.bramwena = cpu_write;
      end
    end
  end

endmodule

// File: tb/tb_extmem_arbiter.sv
// Randomised and directed bench for extmem_arbiter with a BRAM model,
// a reference memory and a per-port expected-response scoreboard.
module tb_extmem_arbiter;
  import extmem_pkg::*;

  localparam int unsigned RDLAT  = 2;
  localparam int unsigned STARVE = 4;
  localparam int          LAT    = RDLAT + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  extmem_arbiter_if bus();

  extmem_arbiter #(.RDLAT(RDLAT), .STARVE(STARVE)) dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: unwritten words read back as init_val(addr)
  logic [11:0] mem     [0:32767];
  bit          written [0:32767];
  logic [11:0] pipe    [0:RDLAT-1];

  function automatic logic [11:0] init_val(input logic [14:0] a);
    logic [31:0] t;
    if (a == 15'h1234) return 12'o5252;
    t = 32'(a) * 7 + 3;
    return t[11:0];
  endfunction

  always @(posedge clk) begin
    if (bus.bramenab && bus.bramwena) begin
      mem[bus.bramaddr]     <= bus.bramwdat;
      written[bus.bramaddr] <= 1'b1;
    end
    if (bus.bramenab && !bus.bramwena)
      pipe[0] <= written[bus.bramaddr] ? mem[bus.bramaddr] : init_val(bus.bramaddr);
    for (int i = 1; i < RDLAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.bramrdat = pipe[RDLAT-1];

  // Reference model: memory contents and per-port expected rdat after each completion
  logic [11:0] ref_mem [int];
  logic [11:0] cpu_q[$];
  logic [11:0] arm_q[$];
  bit          exp_order[$];
  logic [11:0] cpu_last = '0;
  logic [11:0] arm_last = '0;

  function automatic logic [11:0] ref_read(input logic [14:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input bit port, input logic [14:0] a, input bit wr, input logic [11:0] d);
    logic [11:0] e;
    if (wr) begin
      e = port ? arm_last : cpu_last;
      ref_mem[int'(a)] = d;
    end else begin
      e = ref_read(a);
    end
    if (port) begin
      arm_last = e;
      arm_q.push_back(e);
      bus.armstrobe = 1'b1; bus.armaddr = a; bus.armwrite = wr; bus.armwdat = d;
    end else begin
      cpu_last = e;
      cpu_q.push_back(e);
      bus.cpustrobe = 1'b1; bus.cpuaddr = a; bus.cpuwrite = wr; bus.cpuwdat = d;
    end
  endtask

  task automatic undrive(input bit port);
    if (port) bus.armstrobe = 1'b0;
    else      bus.cpustrobe = 1'b0;
  endtask

  task automatic issue(input bit port, input logic [14:0] a, input bit wr,
                       input logic [11:0] d, output int n);
    drive(port, a, wr, d);
    n = cyc;
    tick();
    undrive(port);
  endtask

  task automatic wait_port(input bit port, input string name);
    int budget = 100;
    while ((port ? arm_q.size() : cpu_q.size()) != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if ((port ? arm_q.size() : cpu_q.size()) != 0) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done expected done within budget", name);
      if (port) arm_q.delete(); else cpu_q.delete();
    end
  endtask

  task automatic wait_empty(input string name);
    wait_port(1'b0, name);
    wait_port(1'b1, name);
  endtask

  // Monitor: pops expectations whenever the DUT presents a done pulse
  int  cpu_done_cyc = 0, arm_done_cyc = 0;
  int  arm_dones = 0, enab_cnt = 0, wena_cnt = 0;
  bit  in_reset = 1'b1;

  task automatic check_done(input bit port, input logic [11:0] rd);
    logic [11:0] e;
    int sz;
    sz = port ? arm_q.size() : cpu_q.size();
    if (sz == 0) begin
      total++; bad++;
      $display("FAIL unexpected_done: port %0d got done expected none", port);
    end else begin
      if (port) e = arm_q.pop_front();
      else      e = cpu_q.pop_front();
      chk(port ? "arm_rdat" : "cpu_rdat", 32'(rd), 32'(e));
      if (exp_order.size() != 0) chk("grant_order", 32'(port), 32'(exp_order.pop_front()));
    end
  endtask

  always @(negedge clk) begin
    if (!in_reset) begin
      if (bus.bramenab) enab_cnt++;
      if (bus.bramwena) wena_cnt++;
      if (bus.cpudone) begin
        chk("single_done", 32'(bus.armdone), 32'd0);
        cpu_done_cyc = cyc;
        check_done(1'b0, bus.cpurdat);
      end
      if (bus.armdone) begin
        arm_dones++;
        arm_done_cyc = cyc;
        check_done(1'b1, bus.armrdat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e0, w0, a0;
    bus.cpustrobe = 1'b0; bus.cpuaddr = '0; bus.cpuwrite = 1'b0; bus.cpuwdat = '0;
    bus.armstrobe = 1'b0; bus.armaddr = '0; bus.armwrite = 1'b0; bus.armwdat = '0;
    repeat (3) tick();
    chk("rst_cpurdat", 32'(bus.cpurdat), 0);
    chk("rst_armrdat", 32'(bus.armrdat), 0);
    chk("rst_enab",    32'(bus.bramenab), 0);
    chk("rst_err",     32'(bus.errflag), 0);
    rst_n = 1'b1; in_reset = 1'b0;
    repeat (2) tick();

    // Lone CPU read
    e0 = enab_cnt; w0 = wena_cnt; a0 = arm_dones;
    issue(1'b0, 15'h1234, 1'b0, '0, n);
    chk("lone_enab", 32'(bus.bramenab), 1);
    chk("lone_addr", 32'(bus.bramaddr), 32'h1234);
    wait_empty("lone");
    chk("lone_lat",        32'(cpu_done_cyc - n), 32'(LAT));
    chk("lone_enab_cycles", 32'(enab_cnt - e0), 32'(RDLAT + 1));
    chk("lone_wena_cycles", 32'(wena_cnt - w0), 0);
    chk("lone_no_armdone",  32'(arm_dones - a0), 0);
    repeat (3) tick();
    chk("lone_hold", 32'(bus.cpurdat), 32'(12'o5252));

    // ARM write then CPU read-back
    e0 = enab_cnt; w0 = wena_cnt;
    issue(1'b1, 15'h7FFF, 1'b1, 12'o7777, n);
    wait_empty("armwr");
    chk("armwr_lat",         32'(arm_done_cyc - n), 32'(LAT));
    chk("armwr_enab_cycles", 32'(enab_cnt - e0), 32'(RDLAT + 1));
    chk("armwr_wena_cycles", 32'(wena_cnt - w0), 32'(RDLAT + 1));
    issue(1'b0, 15'h7FFF, 1'b0, '0, n);
    wait_empty("readback");

    // Simultaneous strobes: cpu first, then arm
    exp_order.push_back(1'b0); exp_order.push_back(1'b1);
    drive(1'b0, 15'h0010, 1'b0, '0);
    drive(1'b1, 15'h0020, 1'b0, '0);
    n = cyc;
    tick();
    undrive(1'b0); undrive(1'b1);
    wait_empty("simul");
    chk("simul_cpu_lat", 32'(cpu_done_cyc - n), 32'(LAT));

    // Starvation: cpu re-strobes in every done cycle while arm waits
    for (int k = 0; k < int'(STARVE); k++) exp_order.push_back(1'b0);
    exp_order.push_back(1'b1);
    exp_order.push_back(1'b0);
    drive(1'b0, 15'h0040, 1'b0, '0);
    drive(1'b1, 15'h4040, 1'b0, '0);
    tick();
    undrive(1'b0); undrive(1'b1);
    for (int k = 1; k <= int'(STARVE); k++) begin
      wait_port(1'b0, "starve_cpu");
      issue(1'b0, 15'(15'h0040 + k), 1'b0, '0, n);
    end
    wait_empty("starve");
    chk("starve_order_used", 32'(exp_order.size()), 0);
    exp_order.delete();

    // Double strobe: second request ignored, errflag set
    chk("err_clear_before", 32'(bus.errflag), 0);
    issue(1'b0, 15'h0100, 1'b0, '0, n);
    bus.cpustrobe = 1'b1; bus.cpuaddr = 15'h0200; bus.cpuwrite = 1'b1; bus.cpuwdat = 12'h555;
    tick();
    bus.cpustrobe = 1'b0;
    chk("err_set",        32'(bus.errflag), 1);
    chk("err_addr_kept",  32'(bus.bramaddr), 32'h0100);
    wait_empty("dbl");

    // Random traffic; cpu uses the low address half, arm the high half
    fork
      begin
        int m;
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) tick();
          wait_port(1'b0, "rnd_cpu");
          issue(1'b0, {1'b0, 14'($urandom)}, 1'($urandom_range(0, 1)), 12'($urandom), m);
        end
      end
      begin
        int m;
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) tick();
          wait_port(1'b1, "rnd_arm");
          issue(1'b1, {1'b1, 14'($urandom)}, 1'($urandom_range(0, 1)), 12'($urandom), m);
        end
      end
    join
    wait_empty("rnd");
    chk("err_sticky", 32'(bus.errflag), 1);

    // Reset during the second enab cycle of an arm write
    issue(1'b1, 15'h4444, 1'b1, 12'hABC, n);
    tick();
    chk("mid_enab", 32'(bus.bramenab), 1);
    chk("mid_wena", 32'(bus.bramwena), 1);
    in_reset = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_enab", 32'(bus.bramenab), 0);
    chk("rst_async_wena", 32'(bus.bramwena), 0);
    chk("rst_async_addr", 32'(bus.bramaddr), 0);
    chk("rst_async_done", 32'(bus.armdone), 0);
    chk("rst_async_cpurdat", 32'(bus.cpurdat), 0);
    chk("rst_async_armrdat", 32'(bus.armrdat), 0);
    chk("rst_async_err", 32'(bus.errflag), 0);
    cpu_q.delete(); arm_q.delete(); exp_order.delete();
    cpu_last = '0; arm_last = '0;
    tick(); tick();
    rst_n = 1'b1; in_reset = 1'b0;
    a0 = arm_dones;
    tick();
    issue(1'b1, 15'h4100, 1'b0, '0, n);
    wait_empty("post_rst");
    chk("post_rst_lat",   32'(arm_done_cyc - n), 32'(LAT));
    chk("post_rst_dones", 32'(arm_dones - a0), 1);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
